// File: rtl/fetch_pkg.sv
// Shared constants and types for the RV32I instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam int unsigned PC_STEP          = 4;
    localparam int unsigned DEFAULT_ADDR_W   = 8;
    localparam logic [DEFAULT_ADDR_W-1:0] DEFAULT_RESET_PC = '0;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] pc;
        logic [INSTR_W-1:0]        instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries; flush and rst clear it.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count
);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, addresses the registered ROM and buffers words for decode.
// Optional FETCH_MISALIGN_EN: misaligned redirects halt fetch and raise sticky out_misalign.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned         ADDR_W    = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0]   RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned         BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_dout,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
`ifdef FETCH_MISALIGN_EN
    ,
    output logic               out_misalign
`endif
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [ADDR_W-1:0] target_pc;
    logic              halted;
    logic              misalign;
    logic              issue;
    logic              pop;
    logic              push;
    logic [CNT_W:0]    occupancy;
    logic [CNT_W-1:0]  count;
    entry_t            head;
    entry_t            push_data;

`ifdef FETCH_MISALIGN_EN
    logic halted_q, halted_d;

    assign misalign  = |redirect_pc[1:0];
    assign target_pc = redirect_pc;
    assign halted    = halted_q;
    // Any redirect re-evaluates the halt: misaligned sets it, aligned clears it.
    assign halted_d  = redirect_valid ? misalign : halted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign out_misalign = halted_q;
`else
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign misalign            = 1'b0;
    assign halted              = 1'b0;
    assign target_pc           = {redirect_pc[ADDR_W-1:2], 2'b00};
`endif

    assign rom_addr  = redirect_valid ? target_pc : fetch_pc_q;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A redirect discards the read already in flight.
    assign push      = inflight_q && !redirect_valid;
    assign push_data = '{pc: inflight_pc_q, instr: rom_dout};
    assign occupancy = (CNT_W + 1)'(count) + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);

    always_comb begin
        issue         = 1'b0;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        fetch_pc_d    = fetch_pc_q;
        if (redirect_valid) begin
            issue = !misalign;
        end else begin
            issue = !halted && (occupancy < (CNT_W + 1)'(BUF_DEPTH));
        end
        if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = rom_addr;
            fetch_pc_d    = rom_addr + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (BUF_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign out_instr = out_valid ? head.instr : '0;
    assign out_pc    = out_valid ? head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: ROM model plus a queue scoreboard of accepted PCs.
module tb_fetch_unit;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned BUF_DEPTH = 2;
    localparam logic [7:0]  RESET_PC  = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rom_addr;
    logic [31:0] rom_dout;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
`ifdef FETCH_MISALIGN_EN
    logic        out_misalign;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  exp_pc[$];
    logic [7:0]  obs_pc[$];
    logic [31:0] obs_instr[$];

    fetch_unit #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_dout       (rom_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef FETCH_MISALIGN_EN
        ,
        .out_misalign   (out_misalign)
`endif
    );

    always #5 clk = ~clk;

    // Registered ROM: word at byte A reads back as 0xA500_0000 | A.
    always @(posedge clk) rom_dout <= 32'hA500_0000 | {24'h0, rom_addr};

    // Record every handshake that the next rising edge will complete.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            obs_pc.push_back(out_pc);
            obs_instr.push_back(out_instr);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        step(2);
        obs_pc.delete();
        obs_instr.delete();
        exp_pc.delete();
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        do_reset();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", out_instr); else n_pass++;
        n_checks++; if (out_pc !== 8'h00) $display("FAIL reset_pc: got %h want 00", out_pc); else n_pass++;
        n_checks++; if (rom_addr !== RESET_PC) $display("FAIL reset_rom_addr: got %h want %h", rom_addr, RESET_PC); else n_pass++;
`ifdef FETCH_MISALIGN_EN
        n_checks++; if (out_misalign !== 1'b0) $display("FAIL reset_misalign: got %b want 0", out_misalign); else n_pass++;
`endif
    endtask

    task automatic test_stream();
        logic [7:0] e, p;
        logic [31:0] w;
        do_reset();
        out_ready = 1'b1;
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_n0_valid: got %b want 0", out_valid); else n_pass++;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_n1_valid: got %b want 0", out_valid); else n_pass++;
        step();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL stream_n2_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_pc !== RESET_PC) $display("FAIL stream_n2_pc: got %h want %h", out_pc, RESET_PC); else n_pass++;
        for (int i = 0; i < 5; i++) exp_pc.push_back(RESET_PC + 8'(4 * i));
        step(5);
        n_checks++; if (obs_pc.size() !== 5) $display("FAIL stream_count: got %0d want 5", obs_pc.size()); else n_pass++;
        while (exp_pc.size() > 0) begin
            e = exp_pc.pop_front();
            n_checks++;
            if (obs_pc.size() == 0) begin
                $display("FAIL stream_missing: got none want pc %h", e);
            end else begin
                p = obs_pc.pop_front();
                w = obs_instr.pop_front();
                if (p !== e || w !== (32'hA500_0000 | {24'h0, e}))
                    $display("FAIL stream_entry: got pc %h instr %h want pc %h", p, w, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] e, p;
        logic [31:0] w;
        do_reset();
        out_ready = 1'b0;
        rst = 1'b0;
        step(2);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 8'h00)
                $display("FAIL stall_head: cycle %0d got valid %b pc %h want 1 00", i, out_valid, out_pc);
            else n_pass++;
            step();
        end
        out_ready = 1'b1;
        exp_pc.push_back(8'h00);
        exp_pc.push_back(8'h04);
        exp_pc.push_back(8'h08);
        step(3);
        n_checks++; if (obs_pc.size() !== 3) $display("FAIL stall_count: got %0d want 3", obs_pc.size()); else n_pass++;
        while (exp_pc.size() > 0) begin
            e = exp_pc.pop_front();
            n_checks++;
            if (obs_pc.size() == 0) begin
                $display("FAIL stall_missing: got none want pc %h", e);
            end else begin
                p = obs_pc.pop_front();
                w = obs_instr.pop_front();
                if (p !== e || w !== (32'hA500_0000 | {24'h0, e}))
                    $display("FAIL stall_entry: got pc %h instr %h want pc %h", p, w, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_redirect();
        logic [7:0] e, p;
        logic [31:0] w;
        do_reset();
        out_ready = 1'b1;
        rst = 1'b0;
        step(4);
        n_checks++; if (out_pc !== 8'h08) $display("FAIL redir_head: got %h want 08", out_pc); else n_pass++;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        #1;
        n_checks++; if (rom_addr !== 8'h40) $display("FAIL redir_rom_addr: got %h want 40", rom_addr); else n_pass++;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL redir_r1_valid: got %b want 0", out_valid); else n_pass++;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'h40)
            $display("FAIL redir_r2_head: got valid %b pc %h want 1 40", out_valid, out_pc);
        else n_pass++;
        step(2);
        exp_pc.push_back(8'h00);
        exp_pc.push_back(8'h04);
        exp_pc.push_back(8'h08);
        exp_pc.push_back(8'h40);
        exp_pc.push_back(8'h44);
        n_checks++; if (obs_pc.size() !== 5) $display("FAIL redir_count: got %0d want 5", obs_pc.size()); else n_pass++;
        while (exp_pc.size() > 0) begin
            e = exp_pc.pop_front();
            n_checks++;
            if (obs_pc.size() == 0) begin
                $display("FAIL redir_missing: got none want pc %h", e);
            end else begin
                p = obs_pc.pop_front();
                w = obs_instr.pop_front();
                if (p !== e || w !== (32'hA500_0000 | {24'h0, e}))
                    $display("FAIL redir_entry: got pc %h instr %h want pc %h", p, w, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] e, p;
        logic [31:0] w;
        do_reset();
        out_ready = 1'b1;
        rst = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 8'hF8;
        step();
        redirect_valid = 1'b0;
        step(5);
        exp_pc.push_back(8'hF8);
        exp_pc.push_back(8'hFC);
        exp_pc.push_back(8'h00);
        exp_pc.push_back(8'h04);
        n_checks++; if (obs_pc.size() !== 4) $display("FAIL wrap_count: got %0d want 4", obs_pc.size()); else n_pass++;
        while (exp_pc.size() > 0) begin
            e = exp_pc.pop_front();
            n_checks++;
            if (obs_pc.size() == 0) begin
                $display("FAIL wrap_missing: got none want pc %h", e);
            end else begin
                p = obs_pc.pop_front();
                w = obs_instr.pop_front();
                if (p !== e || w !== (32'hA500_0000 | {24'h0, e}))
                    $display("FAIL wrap_entry: got pc %h instr %h want pc %h", p, w, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e, p;
        logic [31:0] w;
        do_reset();
        out_ready = 1'b0;
        rst = 1'b0;
        step(4);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL rmid_full_valid: got %b want 1", out_valid); else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_after_valid: got %b want 0", out_valid); else n_pass++;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_n1_valid: got %b want 0", out_valid); else n_pass++;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== RESET_PC)
            $display("FAIL rmid_restart: got valid %b pc %h want 1 %h", out_valid, out_pc, RESET_PC);
        else n_pass++;
        out_ready = 1'b1;
        exp_pc.push_back(8'h00);
        exp_pc.push_back(8'h04);
        exp_pc.push_back(8'h08);
        step(3);
        n_checks++; if (obs_pc.size() !== 3) $display("FAIL rmid_count: got %0d want 3", obs_pc.size()); else n_pass++;
        while (exp_pc.size() > 0) begin
            e = exp_pc.pop_front();
            n_checks++;
            if (obs_pc.size() == 0) begin
                $display("FAIL rmid_missing: got none want pc %h", e);
            end else begin
                p = obs_pc.pop_front();
                w = obs_instr.pop_front();
                if (p !== e || w !== (32'hA500_0000 | {24'h0, e}))
                    $display("FAIL rmid_entry: got pc %h instr %h want pc %h", p, w, e);
                else n_pass++;
            end
        end
    endtask

`ifdef FETCH_MISALIGN_EN
    task automatic test_misalign();
        logic [7:0] e, p;
        logic [31:0] w;
        do_reset();
        out_ready = 1'b1;
        rst = 1'b0;
        step(3);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h42;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (out_misalign !== 1'b1) $display("FAIL mis_flag_set: got %b want 1", out_misalign); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mis_valid_r1: got %b want 0", out_valid); else n_pass++;
        step(3);
        n_checks++;
        if (out_valid !== 1'b0 || out_misalign !== 1'b1)
            $display("FAIL mis_halted: got valid %b flag %b want 0 1", out_valid, out_misalign);
        else n_pass++;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h44;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (out_misalign !== 1'b0) $display("FAIL mis_flag_clear: got %b want 0", out_misalign); else n_pass++;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'h44)
            $display("FAIL mis_resume: got valid %b pc %h want 1 44", out_valid, out_pc);
        else n_pass++;
        step();
        exp_pc.push_back(8'h00);
        exp_pc.push_back(8'h04);
        exp_pc.push_back(8'h44);
        n_checks++; if (obs_pc.size() !== 3) $display("FAIL mis_count: got %0d want 3", obs_pc.size()); else n_pass++;
        while (exp_pc.size() > 0) begin
            e = exp_pc.pop_front();
            n_checks++;
            if (obs_pc.size() == 0) begin
                $display("FAIL mis_missing: got none want pc %h", e);
            end else begin
                p = obs_pc.pop_front();
                w = obs_instr.pop_front();
                if (p !== e || w !== (32'hA500_0000 | {24'h0, e}))
                    $display("FAIL mis_entry: got pc %h instr %h want pc %h", p, w, e);
                else n_pass++;
            end
        end
    endtask
`else
    task automatic test_align_force();
        do_reset();
        out_ready = 1'b1;
        rst = 1'b0;
        step(3);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h42;
        #1;
        n_checks++; if (rom_addr !== 8'h40) $display("FAIL align_rom_addr: got %h want 40", rom_addr); else n_pass++;
        step();
        redirect_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'h40 || out_instr !== 32'hA500_0040)
            $display("FAIL align_head: got valid %b pc %h instr %h want 1 40 a5000040",
                     out_valid, out_pc, out_instr);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
`ifdef FETCH_MISALIGN_EN
        test_misalign();
`else
        test_align_force();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
